// File: rtl/gpio_conv_bridge_if.sv
// Signal bundle between the GPIO-side bridge and its neighbours (firmware GPIO pair + convolution cores).
// slave modport is the bridge view; master modport is the view of whatever drives the bridge.
interface gpio_conv_bridge_if #(
  parameter int GPIO_D   = 32,
  parameter int BIT_LEN  = 8,
  parameter int CONV_LEN = 20
);
  logic [GPIO_D-1:0]   i_gpio_cmd;
  logic [GPIO_D-1:0]   o_gpio_rsp;
  logic [1:0]          o_ch_sel;
  logic                o_kernel_we;
  logic [3:0]          o_kernel_addr;
  logic [BIT_LEN-1:0]  o_kernel_data;
  logic                o_pix_valid;
  logic [BIT_LEN-1:0]  o_pix_data;
  logic                i_pix_ready;
  logic                o_start;
  logic                o_core_rst;
  logic                i_result_valid;
  logic [CONV_LEN-1:0] i_result;

  modport slave (
    input  i_gpio_cmd, i_pix_ready, i_result_valid, i_result,
    output o_gpio_rsp, o_ch_sel, o_kernel_we, o_kernel_addr, o_kernel_data,
           o_pix_valid, o_pix_data, o_start, o_core_rst
  );

  modport master (
    output i_gpio_cmd, i_pix_ready, i_result_valid, i_result,
    input  o_gpio_rsp, o_ch_sel, o_kernel_we, o_kernel_addr, o_kernel_data,
           o_pix_valid, o_pix_data, o_start, o_core_rst
  );
endinterface

// File: rtl/gpio_conv_bridge.sv
// Purpose: toggle-strobed GPIO command decoder driving N_CH conv cores, with a result FIFO drained over GPIO.
// Latency: ack visible 3 cycles after the toggle edge is sampled (LOAD_PIXEL adds the pixel handshake wait).
// Backpressure: pixel held until i_pix_ready; toggles ignored while busy; full FIFO drops results and sets error.
// Optional: define CMD_PARITY_EN to require even parity over the whole command word.
module gpio_conv_bridge #(
  parameter int GPIO_D     = 32,
  parameter int BIT_LEN    = 8,
  parameter int CONV_LEN   = 20,
  parameter int M_LEN      = 3,
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input logic               CLK100MHZ,
  input logic               ck_rst,
  gpio_conv_bridge_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int KN    = M_LEN * M_LEN;

  localparam logic [2:0] OP_LK  = 3'd1;
  localparam logic [2:0] OP_LP  = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_RD  = 3'd4;
  localparam logic [2:0] OP_RST = 3'd5;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_PIX, ACK} state_t;
  state_t state, state_nxt;

  logic               tog_q, ack_q, err_q, ok_q;
  logic [2:0]         op_q;
  logic [3:0]         idx_q;
  logic [BIT_LEN-1:0] dat_q;
  logic [1:0]         ch_sel_q;
  logic [19:0]        data_q;

  logic [CONV_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  logic cmd_new, cmd_legal, par_ok, idx_ok;
  logic kernel_we, start, core_rst, pop_req, flush, err_set;
  logic pop_ok, push_ok, fifo_empty, fifo_full;
  logic unused_cmd;

  assign cmd_new = (state == IDLE) && (bus.i_gpio_cmd[31] != tog_q);

`ifdef CMD_PARITY_EN
  assign par_ok     = ~(^bus.i_gpio_cmd);
  assign unused_cmd = ^bus.i_gpio_cmd[20:BIT_LEN];
`else
  assign par_ok     = 1'b1;
  assign unused_cmd = ^{bus.i_gpio_cmd[30], bus.i_gpio_cmd[20:BIT_LEN]};
`endif

  // Commands failing decode are still acked but flagged and have no side effect.
  assign cmd_legal = par_ok && (bus.i_gpio_cmd[29:27] <= OP_RST) &&
                     (int'(bus.i_gpio_cmd[26:25]) < N_CH);
  assign idx_ok    = int'(idx_q) < KN;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop_ok     = pop_req && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = bus.i_result_valid && !flush && (!fifo_full || pop_ok);

  // State register.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and single-cycle command strobes.
  always_comb begin
    state_nxt = state;
    kernel_we = 1'b0;
    start     = 1'b0;
    core_rst  = 1'b0;
    pop_req   = 1'b0;
    flush     = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: if (cmd_new) state_nxt = EXEC;
      EXEC: begin
        state_nxt = ACK;
        if (!ok_q) err_set = 1'b1;
        else begin
          case (op_q)
            OP_LK:  if (idx_ok) kernel_we = 1'b1; else err_set = 1'b1;
            OP_LP:  state_nxt = WAIT_PIX;
            OP_ST:  start = 1'b1;
            OP_RD:  pop_req = 1'b1;
            OP_RST: begin core_rst = 1'b1; flush = 1'b1; end
            default: ;
          endcase
        end
      end
      WAIT_PIX: if (bus.i_pix_ready) state_nxt = ACK;
      ACK:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Capture the command fields when a new toggle is accepted.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      tog_q    <= 1'b0;
      ok_q     <= 1'b0;
      op_q     <= '0;
      idx_q    <= '0;
      dat_q    <= '0;
      ch_sel_q <= '0;
    end else if (cmd_new) begin
      tog_q <= bus.i_gpio_cmd[31];
      ok_q  <= cmd_legal;
      op_q  <= bus.i_gpio_cmd[29:27];
      idx_q <= bus.i_gpio_cmd[24:21];
      dat_q <= bus.i_gpio_cmd[BIT_LEN-1:0];
      if (cmd_legal) ch_sel_q <= bus.i_gpio_cmd[26:25];
    end
  end

  // Ack toggle, sticky error and read-data response fields.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (state == ACK) ack_q <= tog_q;
      if (flush) err_q <= 1'b0;
      else if (err_set || (pop_req && !pop_ok) ||
               (bus.i_result_valid && fifo_full && !pop_ok)) err_q <= 1'b1;
      if (pop_req) data_q <= pop_ok ? 20'(mem[rd_ptr]) : '0;
    end
  end

  // Result FIFO pointers and occupancy; soft reset empties it.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Result FIFO storage.
  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) mem[wr_ptr] <= bus.i_result;
  end

  assign bus.o_gpio_rsp    = GPIO_D'({ack_q, (state != IDLE), err_q, fifo_empty, fifo_full,
                                       2'b00, 5'(count), data_q});
  assign bus.o_ch_sel      = ch_sel_q;
  assign bus.o_kernel_we   = kernel_we;
  assign bus.o_kernel_addr = kernel_we ? idx_q : '0;
  assign bus.o_kernel_data = kernel_we ? dat_q : '0;
  assign bus.o_pix_valid   = (state == WAIT_PIX);
  assign bus.o_pix_data    = (state == WAIT_PIX) ? dat_q : '0;
  assign bus.o_start       = start;
  assign bus.o_core_rst    = core_rst;
endmodule

// File: tb/tb_gpio_conv_bridge.sv
// Directed bench for gpio_conv_bridge: table of single commands plus hand sequences
// for pixel handshake, FIFO corner cases, parity option and reset during a pixel wait.
module tb_gpio_conv_bridge;
  logic clk;
  logic ck_rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic tog = 1'b0;

  gpio_conv_bridge_if #(.GPIO_D(32), .BIT_LEN(8), .CONV_LEN(20)) bus ();

  gpio_conv_bridge #(
    .GPIO_D(32), .BIT_LEN(8), .CONV_LEN(20), .M_LEN(3), .N_CH(4), .FIFO_DEPTH(16)
  ) dut (
    .CLK100MHZ(clk),
    .ck_rst(ck_rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] ch;
    logic [3:0] idx;
    logic [7:0] dat;
    int         we_n;
    int         st_n;
    int         cr_n;
    logic       err;
    logic       chk_ch;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] mk_cmd(input logic t, input logic [2:0] op, input logic [1:0] ch,
                                         input logic [24:0] pl, input logic bad);
    logic [31:0] w;
    w = {t, 1'b0, op, ch, pl};
    w[30] = (^w) ^ bad;
    return w;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [24:0] pl, input logic bad);
    tog = ~tog;
    @(negedge clk);
    bus.i_gpio_cmd = mk_cmd(tog, op, ch, pl, bad);
  endtask

  task automatic watch(output int we_n, output logic [3:0] ka, output logic [7:0] kd,
                       output int st_n, output int cr_n, output int lat, output logic got);
    we_n = 0; st_n = 0; cr_n = 0; lat = 0; got = 1'b0; ka = '0; kd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.o_kernel_we) begin we_n++; ka = bus.o_kernel_addr; kd = bus.o_kernel_data; end
      if (bus.o_start) st_n++;
      if (bus.o_core_rst) cr_n++;
      if (bus.o_gpio_rsp[31] == tog && !bus.o_gpio_rsp[30]) begin got = 1'b1; lat = c; break; end
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] ch, input logic [24:0] pl, input logic bad,
                        output int we_n, output logic [3:0] ka, output logic [7:0] kd,
                        output int st_n, output int cr_n, output int lat, output logic got);
    issue(op, ch, pl, bad);
    watch(we_n, ka, kd, st_n, cr_n, lat, got);
  endtask

  // READ_RESULT with a result pushed during the command's execute cycle.
  task automatic read_with_push(input logic [19:0] val, output logic got);
    int we_n, st_n, cr_n, lat;
    logic [3:0] ka;
    logic [7:0] kd;
    issue(3'd4, 2'd0, 25'd0, 1'b0);
    @(negedge clk);
    bus.i_result_valid = 1'b1;
    bus.i_result = val;
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    watch(we_n, ka, kd, st_n, cr_n, lat, got);
  endtask

  initial begin
    int we_n, st_n, cr_n, lat, vcnt;
    logic [3:0] ka;
    logic [7:0] kd;
    logic got, busy_bad, data_bad, seen;

    tbl[0] = '{3'd1, 2'd2, 4'd4, 8'h7F, 1, 0, 0, 1'b0, 1'b1, 2'd2};
    tbl[1] = '{3'd1, 2'd1, 4'd8, 8'h01, 1, 0, 0, 1'b0, 1'b1, 2'd1};
    tbl[2] = '{3'd3, 2'd3, 4'd0, 8'h00, 0, 1, 0, 1'b0, 1'b1, 2'd3};
    tbl[3] = '{3'd0, 2'd0, 4'd0, 8'h00, 0, 0, 0, 1'b0, 1'b1, 2'd0};
    tbl[4] = '{3'd1, 2'd0, 4'd9, 8'h55, 0, 0, 0, 1'b1, 1'b1, 2'd0};
    tbl[5] = '{3'd5, 2'd1, 4'd0, 8'h00, 0, 0, 1, 1'b0, 1'b1, 2'd1};
    tbl[6] = '{3'd6, 2'd2, 4'd0, 8'h00, 0, 0, 0, 1'b1, 1'b0, 2'd0};
    tbl[7] = '{3'd7, 2'd3, 4'd0, 8'h00, 0, 0, 0, 1'b1, 1'b0, 2'd0};
    tbl[8] = '{3'd5, 2'd0, 4'd0, 8'h00, 0, 0, 1, 1'b0, 1'b1, 2'd0};
    tbl[9] = '{3'd3, 2'd0, 4'd0, 8'h00, 0, 1, 0, 1'b0, 1'b1, 2'd0};

    ck_rst = 1'b0;
    bus.i_gpio_cmd = '0;
    bus.i_pix_ready = 1'b0;
    bus.i_result_valid = 1'b0;
    bus.i_result = '0;
    repeat (3) @(negedge clk);
    ck_rst = 1'b1;
    @(negedge clk);
    check("reset_rsp", bus.o_gpio_rsp, 32'h1000_0000);
    check("reset_strobes", {bus.o_kernel_we, bus.o_start, bus.o_core_rst, bus.o_pix_valid}, 0);
    check("reset_chsel", bus.o_ch_sel, 0);

    for (int i = 0; i < 10; i++) begin
      do_cmd(tbl[i].op, tbl[i].ch, {tbl[i].idx, 13'd0, tbl[i].dat}, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
      check($sformatf("vec%0d_ack", i), got, 1);
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_we", i), we_n, tbl[i].we_n);
      if (tbl[i].we_n == 1) begin
        check($sformatf("vec%0d_kaddr", i), ka, tbl[i].idx);
        check($sformatf("vec%0d_kdata", i), kd, tbl[i].dat);
      end
      check($sformatf("vec%0d_start", i), st_n, tbl[i].st_n);
      check($sformatf("vec%0d_crst", i), cr_n, tbl[i].cr_n);
      check($sformatf("vec%0d_err", i), bus.o_gpio_rsp[29], tbl[i].err);
      if (tbl[i].chk_ch) check($sformatf("vec%0d_chsel", i), bus.o_ch_sel, tbl[i].exp_ch);
    end

    // Pixel with ready low for 5 valid cycles.
    issue(3'd2, 2'd1, 25'h0A5, 1'b0);
    vcnt = 0; busy_bad = 1'b0; data_bad = 1'b0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.o_pix_valid) begin
        vcnt++;
        if (!bus.o_gpio_rsp[30]) busy_bad = 1'b1;
        if (bus.o_pix_data !== 8'hA5 || bus.o_ch_sel !== 2'd1) data_bad = 1'b1;
        if (vcnt == 6) bus.i_pix_ready = 1'b1;
      end else bus.i_pix_ready = 1'b0;
      if (bus.o_gpio_rsp[31] == tog && !bus.o_gpio_rsp[30]) got = 1'b1;
    end
    check("pix_valid_cycles", vcnt, 6);
    check("pix_busy_held", busy_bad, 0);
    check("pix_data_held", data_bad, 0);
    check("pix_ack", got, 1);

    // FIFO fill beyond depth.
    check("fifo_pre_count", bus.o_gpio_rsp[24:20], 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.i_result_valid = 1'b1;
      bus.i_result = 20'(100 + i);
    end
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    @(negedge clk);
    check("fill_count", bus.o_gpio_rsp[24:20], 16);
    check("fill_full", bus.o_gpio_rsp[27], 1);
    check("fill_err", bus.o_gpio_rsp[29], 1);
    check("fill_empty", bus.o_gpio_rsp[28], 0);
    do_cmd(3'd4, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("rd1_data", bus.o_gpio_rsp[19:0], 100);
    check("rd1_count", bus.o_gpio_rsp[24:20], 15);
    check("rd1_full", bus.o_gpio_rsp[27], 0);
    do_cmd(3'd4, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("rd2_data", bus.o_gpio_rsp[19:0], 101);
    do_cmd(3'd5, 2'd2, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("srst1_crst", cr_n, 1);
    check("srst1_err", bus.o_gpio_rsp[29], 0);
    check("srst1_empty", bus.o_gpio_rsp[28], 1);
    check("srst1_count", bus.o_gpio_rsp[24:20], 0);
    do_cmd(3'd4, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("rd_empty_data", bus.o_gpio_rsp[19:0], 0);
    check("rd_empty_err", bus.o_gpio_rsp[29], 1);
    do_cmd(3'd5, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("srst2_err", bus.o_gpio_rsp[29], 0);

    // Simultaneous push and pop on a non-empty FIFO.
    @(negedge clk);
    bus.i_result_valid = 1'b1;
    bus.i_result = 20'd200;
    @(negedge clk);
    bus.i_result_valid = 1'b0;
    read_with_push(20'd201, got);
    check("pp_ack", got, 1);
    check("pp_data", bus.o_gpio_rsp[19:0], 200);
    check("pp_count", bus.o_gpio_rsp[24:20], 1);
    check("pp_err", bus.o_gpio_rsp[29], 0);
    do_cmd(3'd4, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("pp_next_data", bus.o_gpio_rsp[19:0], 201);
    check("pp_next_empty", bus.o_gpio_rsp[28], 1);

    // Push into empty with a pop in the same cycle.
    read_with_push(20'hABCDE, got);
    check("pe_data", bus.o_gpio_rsp[19:0], 0);
    check("pe_err", bus.o_gpio_rsp[29], 1);
    check("pe_count", bus.o_gpio_rsp[24:20], 1);
    do_cmd(3'd4, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("pe_next_data", bus.o_gpio_rsp[19:0], 20'hABCDE);
    do_cmd(3'd5, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);

    // Odd-parity START.
    do_cmd(3'd3, 2'd2, 25'd0, 1'b1, we_n, ka, kd, st_n, cr_n, lat, got);
    check("par_ack", got, 1);
`ifdef CMD_PARITY_EN
    check("par_start", st_n, 0);
    check("par_err", bus.o_gpio_rsp[29], 1);
    do_cmd(3'd5, 2'd0, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
`else
    check("par_start", st_n, 1);
    check("par_err", bus.o_gpio_rsp[29], 0);
`endif

    // Reset while waiting for pixel ready.
    bus.i_pix_ready = 1'b0;
    issue(3'd2, 2'd3, 25'h03C, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_pix_valid) seen = 1'b1;
    end
    check("rstpix_valid_seen", seen, 1);
    #2;
    ck_rst = 1'b0;
    bus.i_gpio_cmd = '0;
    #1;
    check("rstpix_valid_drop", bus.o_pix_valid, 0);
    check("rstpix_rsp", bus.o_gpio_rsp, 32'h1000_0000);
    check("rstpix_chsel", bus.o_ch_sel, 0);
    @(negedge clk);
    ck_rst = 1'b1;
    tog = 1'b0;
    do_cmd(3'd3, 2'd2, 25'd0, 1'b0, we_n, ka, kd, st_n, cr_n, lat, got);
    check("post_rst_start", st_n, 1);
    check("post_rst_lat", lat, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_conv_bridge.md
Name: gpio_conv_bridge

Overview:
Command/response bridge between the MicroBlaze 32-bit GPIO pair and an array of N_CH 2D-convolution cores. Decodes toggle-strobed command words from the GPIO output, drives kernel/pixel/start strobes to the selected core, and buffers core results in a FIFO that firmware drains through the GPIO input. Sits between design_1 and the convolution datapath, on the microcontroller clock.

Parameters:
GPIO_D, 32, GPIO word width (fixed field layout below, must be 32)
BIT_LEN, 8, pixel and coefficient width
CONV_LEN, 20, result width (≤20)
M_LEN, 3, kernel side; M_LEN*M_LEN coefficients per channel (≤16)
N_CH, 4, number of cores (≤4)
FIFO_DEPTH, 16, result FIFO entries (power of 2, ≤16)

Ports:
CLK100MHZ  in  1  clock
ck_rst  in  1  asynchronous reset, active low
i_gpio_cmd  in  GPIO_D  command word from GPIO output
o_gpio_rsp  out  GPIO_D  response word to GPIO input
o_ch_sel  out  2  target channel
o_kernel_we  out  1  one-cycle coefficient write strobe
o_kernel_addr  out  4  coefficient index
o_kernel_data  out  BIT_LEN  coefficient
o_pix_valid  out  1  pixel valid (held until i_pix_ready)
o_pix_data  out  BIT_LEN  pixel
i_pix_ready  in  1  selected core accepts pixel
o_start  out  1  one-cycle start pulse
o_core_rst  out  1  one-cycle soft reset pulse to all cores
i_result_valid  in  1  result strobe from cores
i_result  in  CONV_LEN  result value

Behaviour:
- Command word: [31] toggle, [30] parity, [29:27] opcode, [26:25] channel, [24:0] payload.
- Opcodes: 0 NOP, 1 LOAD_KERNEL (payload[24:21]=index, [BIT_LEN-1:0]=coef), 2 LOAD_PIXEL ([BIT_LEN-1:0]), 3 START, 4 READ_RESULT, 5 SOFT_RESET, 6-7 illegal.
- Response word: [31] ack toggle, [30] busy, [29] sticky error, [28] fifo empty, [27] fifo full, [24:20] fifo count, [19:0] data (zero-extended result).
- Reset: all outputs 0 except o_gpio_rsp = 0x1000_0000 (empty=1); toggle register 0; FIFO empty; error 0.
- FSM IDLE -> EXEC -> (WAIT_PIX) -> ACK -> IDLE. IDLE: cmd[31] != last toggle registers word, latches toggle, busy=1, goes EXEC next cycle.
- EXEC: LOAD_KERNEL asserts o_kernel_we 1 cycle; index ≥ M_LEN*M_LEN -> no write, error. LOAD_PIXEL raises o_pix_valid, goes WAIT_PIX. START/SOFT_RESET pulse 1 cycle. READ_RESULT pops FIFO head into data; empty -> error, data 0. Illegal opcode or channel ≥ N_CH -> error, no side effect.
- WAIT_PIX: o_pix_valid/o_pix_data/o_ch_sel held until i_pix_ready high; transfer cycle -> ACK. No timeout.
- ACK: rsp[31] = latched toggle, busy=0. Non-waiting command: ack visible 3 cycles after toggle edge sampled.
- Toggle changes while busy ignored until IDLE (firmware must wait for ack).
- FIFO push on i_result_valid in any state; full -> drop, set error. Simultaneous push+pop: both take effect, count unchanged; push into empty + pop same cycle -> pop returns error (push lands).
- SOFT_RESET: flushes FIFO, clears error, kernels untouched, o_core_rst pulse.
- Error cleared only by SOFT_RESET or ck_rst. ck_rst mid-WAIT_PIX drops o_pix_valid immediately.
- o_ch_sel holds last command's channel.

Optional Feature:
CMD_PARITY_EN: defined -> bits [31:0] of command must have even parity (bit 30 parity); mismatch -> command not executed, error set, ack still returned. Undefined -> bit 30 ignored, no parity check.

Test Plan:
- Release reset -> o_gpio_rsp=0x1000_0000, all strobes 0.
- Cmd toggle=1, LOAD_KERNEL ch2 idx 4 coef 0x7F -> one o_kernel_we with addr 4, data 0x7F, ch_sel 2; rsp[31]=1 three cycles later.
- LOAD_PIXEL 0xA5 with i_pix_ready low 5 cycles -> o_pix_valid held 6 cycles, busy=1 throughout, ack after transfer.
- Push 17 results (FIFO_DEPTH 16) -> count 16, full=1, error=1; READ_RESULT returns first value, count 15.
- READ_RESULT on empty FIFO -> data 0, error=1; SOFT_RESET -> error 0, empty 1, o_core_rst pulse.
- With CMD_PARITY_EN, odd-parity START -> no o_start, error=1, ack toggled.
